// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX-stage forwarding selects, load-use bubble insertion,
// dcache-miss freeze and branch-flush handling for a 5-stage rv32i pipeline.
`default_nettype none

module hazard_forward_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             mem_stall,
    input  logic             br_flush,
    output logic [1:0]       EX_forwarding_sel1,
    output logic [1:0]       EX_forwarding_sel2,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic             freeze_all,
    output logic [CNT_W-1:0] load_use_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } tag_t;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_max = '1;
    localparam logic [1:0]       c_sel_reg = 2'b00;
    localparam logic [1:0]       c_sel_wb  = 2'b01;
    localparam logic [1:0]       c_sel_mem = 2'b10;

    tag_t             r_ex;
    tag_t             r_mem;
    tag_t             r_wb;
    logic [4:0]       r_ex_rs1;
    logic [4:0]       r_ex_rs2;
    logic             r_ex_use1;
    logic             r_ex_use2;
    logic [CNT_W-1:0] r_count;
    // Low for the first cycle after reset so every output stays quiet then.
    logic             r_active;

    logic             w_load_use;
    logic             w_do_bubble;
    logic             w_do_stall;
    logic [1:0]       w_sel1;
    logic [1:0]       w_sel2;

    function automatic logic tag_hits(input tag_t t, input logic [4:0] src);
        return t.valid & t.regwrite & (t.rd != 5'd0) & (t.rd == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] src,
                                           input tag_t mem_t, input tag_t wb_t);
        logic [1:0] sel;
        sel = c_sel_reg;
        if (use_src) begin
            if (tag_hits(mem_t, src)) begin
                sel = c_sel_mem;
            end else if (tag_hits(wb_t, src)) begin
                sel = c_sel_wb;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_load_use = id_valid & r_ex.is_load &
                     ((id_use_rs1 & tag_hits(r_ex, id_rs1)) |
                      (id_use_rs2 & tag_hits(r_ex, id_rs2)));
        // A flush already empties EX, so it swallows any load-use stall.
        w_do_bubble = ~mem_stall & (br_flush | w_load_use);
        w_do_stall  = ~mem_stall & ~br_flush & w_load_use;
        w_sel1 = fwd_sel(r_ex.valid & r_ex_use1, r_ex_rs1, r_mem, r_wb);
        w_sel2 = fwd_sel(r_ex.valid & r_ex_use2, r_ex_rs2, r_mem, r_wb);
    end

    assign EX_forwarding_sel1 = r_active ? w_sel1 : c_sel_reg;
    assign EX_forwarding_sel2 = r_active ? w_sel2 : c_sel_reg;
    assign stall_if_id        = r_active & w_do_stall;
    assign bubble_ex          = r_active & w_do_bubble;
    assign freeze_all         = r_active & mem_stall;
    assign load_use_count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex      <= '0;
            r_mem     <= '0;
            r_wb      <= '0;
            r_ex_rs1  <= 5'd0;
            r_ex_rs2  <= 5'd0;
            r_ex_use1 <= 1'b0;
            r_ex_use2 <= 1'b0;
            r_count   <= '0;
            r_active  <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (!mem_stall) begin
                r_wb  <= r_mem;
                r_mem <= r_ex;
                if (w_do_bubble) begin
                    r_ex      <= '0;
                    r_ex_rs1  <= 5'd0;
                    r_ex_rs2  <= 5'd0;
                    r_ex_use1 <= 1'b0;
                    r_ex_use2 <= 1'b0;
                end else begin
                    r_ex      <= '{valid: id_valid, rd: id_rd,
                                   regwrite: id_regwrite, is_load: id_is_load};
                    r_ex_rs1  <= id_rs1;
                    r_ex_rs2  <= id_rs2;
                    r_ex_use1 <= id_use_rs1;
                    r_ex_use2 <= id_use_rs2;
                end
                if (w_do_stall && (r_count != c_max)) begin
                    r_count <= r_count + c_one;
                end
            end
        end
    end

endmodule

`default_nettype wire
